// File: rtl/slow_clock_recovery.sv
// Recovers a slow asynchronous clock (PS/2 keyboard clock) into the clk domain.
// It provides synchronized, glitch-filtered edge strobes, the fall-to-fall period and an idle flag.
module slow_clock_recovery #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT     = 10000,
   parameter int PERIOD_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ext_clk,
   output logic                clk_level,
   output logic                fall_pulse,
   output logic                rise_pulse,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                idle
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0]       FCNT_MAX  = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0]       ICNT_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0]       ICNT_LAST = TW'(TIMEOUT - 1);
   localparam logic [PERIOD_W-1:0] GAP_MAX   = '1;

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [FW-1:0]          fcnt_reg;
   logic                   lvl_reg;
   logic                   fall_reg;
   logic                   rise_reg;
   logic [PERIOD_W-1:0]    gap_reg;
   logic [PERIOD_W-1:0]    period_reg;
   logic                   pv_reg;
   logic                   armed_reg;
   logic [TW-1:0]          icnt_reg;
   logic                   idle_reg;

   logic s;
   logic flip_next;
   logic fall_next;

   assign s = sync_reg[SYNC_STAGES-1];

   always_comb begin
      flip_next = (s != lvl_reg) && (fcnt_reg == FCNT_MAX);
      fall_next = flip_next && lvl_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg   <= '1;
         fcnt_reg   <= '0;
         lvl_reg    <= 1'b1;
         fall_reg   <= 1'b0;
         rise_reg   <= 1'b0;
         gap_reg    <= '0;
         period_reg <= '0;
         pv_reg     <= 1'b0;
         armed_reg  <= 1'b0;
         icnt_reg   <= '0;
         idle_reg   <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], ext_clk};

         // Glitch filter: the level only moves after FILTER_LEN straight disagreeing cycles.
         if (s == lvl_reg) begin
            fcnt_reg <= '0;
         end else if (flip_next) begin
            fcnt_reg <= '0;
            lvl_reg  <= s;
         end else begin
            fcnt_reg <= fcnt_reg + 1'b1;
         end

         fall_reg <= fall_next;
         rise_reg <= flip_next && !lvl_reg;
         pv_reg   <= 1'b0;

         if (fall_next) begin
            gap_reg <= PERIOD_W'(1);
            if (armed_reg) begin
               period_reg <= gap_reg;
               pv_reg     <= 1'b1;
            end
         end else if (gap_reg != GAP_MAX) begin
            gap_reg <= gap_reg + 1'b1;
         end

         // A strobe always beats a simultaneous timeout; idle disarms the period measurement.
         if (flip_next) begin
            icnt_reg <= '0;
            idle_reg <= 1'b0;
            if (fall_next) begin
               armed_reg <= 1'b1;
            end
         end else if (icnt_reg != ICNT_MAX) begin
            icnt_reg <= icnt_reg + 1'b1;
            if (icnt_reg == ICNT_LAST) begin
               idle_reg  <= 1'b1;
               armed_reg <= 1'b0;
            end
         end
      end
   end

   assign clk_level    = lvl_reg;
   assign fall_pulse   = fall_reg;
   assign rise_pulse   = rise_reg;
   assign period       = period_reg;
   assign period_valid = pv_reg;
   assign idle         = idle_reg;

endmodule
